add_rs: RTL and testbench

Reservation station and issue controller for the integer adder functional unit of the Tomasulo core. Accepts add/sub instructions with operand values or producer tags, snoops the common data bus (CDB) for missing operands, and dispatches one ready entry at a time to the registered 32-bit CLA adder. It then holds the adder result on its CDB output port until the arbiter accepts it. It is the initiator that drives the adder's a/b/cin inputs and consumes its sum/cout outputs.

---
 rtl/add_rs.sv | 179 +++++++++++++++++
 tb/tb_add_rs.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_rs.sv
// add_rs: reservation station and issue controller for the integer adder.
// Holds add/sub instructions until both operands are known, snoops the CDB
// for missing operands, and feeds one ready entry at a time to a registered
// adder. The result is then held on the CDB output until the arbiter grants it.
module add_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int RS_BASE = 0,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_op,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic [TAG_W-1:0] issue_qk,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             cdb_in_valid,
    input  logic [TAG_W-1:0] cdb_in_tag,
    input  logic [31:0]      cdb_in_data,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_cin,
    input  logic [31:0]      alu_sum,
    input  logic             alu_cout,
    output logic             cdb_out_valid,
    input  logic             cdb_out_ready,
    output logic [TAG_W-1:0] cdb_out_tag,
    output logic [31:0]      cdb_out_data,
    output logic             cdb_out_cout
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [ENTRIES-1:0] busy_q;
    logic [ENTRIES-1:0] op_q;
    logic [ENTRIES-1:0] disp_q;
    logic [31:0]        vj_q [ENTRIES];
    logic [31:0]        vk_q [ENTRIES];
    logic [TAG_W-1:0]   qj_q [ENTRIES];
    logic [TAG_W-1:0]   qk_q [ENTRIES];
    logic [IDX_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               freeFound;
    logic [IDX_W-1:0]   freeIdx;
    logic [TAG_W-1:0]   freeTag;
    logic               anyReady;
    logic [IDX_W-1:0]   readyIdx;
    logic               issueFire;
    logic               snoopLive;
    logic               bypassJ;
    logic               bypassK;

    // Pick the lowest free slot for issue and the lowest ready slot for dispatch,
    // both from registered state so a freed or newly-ready entry counts next cycle.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        freeTag   = TAG_W'(RS_BASE);
        anyReady  = 1'b0;
        readyIdx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
                freeTag   = TAG_W'(RS_BASE + i);
            end
            if (busy_q[i] && !disp_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0)) begin
                anyReady = 1'b1;
                readyIdx = IDX_W'(i);
            end
        end
    end

    assign issue_ready = freeFound;
    assign issue_tag   = freeTag;
    assign issueFire   = issue_valid && freeFound;
    assign snoopLive   = cdb_in_valid && (cdb_in_tag != '0);
    assign bypassJ     = snoopLive && (issue_qj == cdb_in_tag);
    assign bypassK     = snoopLive && (issue_qk == cdb_in_tag);

    // Entry bookkeeping (snoop, issue, free) and the dispatch/execute/broadcast
    // state machine share one register block because dispatch and release both
    // touch entry state; they never target the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= '0;
            op_q          <= '0;
            disp_q        <= '0;
            sel_q         <= '0;
            cnt_q         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_cin       <= 1'b0;
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_data  <= '0;
            cdb_out_cout  <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy_q[i] && snoopLive) begin
                    if (qj_q[i] == cdb_in_tag) begin
                        vj_q[i] <= cdb_in_data;
                        qj_q[i] <= '0;
                    end
                    if (qk_q[i] == cdb_in_tag) begin
                        vk_q[i] <= cdb_in_data;
                        qk_q[i] <= '0;
                    end
                end
            end

            if (issueFire) begin
                busy_q[freeIdx] <= 1'b1;
                op_q[freeIdx]   <= issue_op;
                disp_q[freeIdx] <= 1'b0;
                vj_q[freeIdx]   <= bypassJ ? cdb_in_data : issue_vj;
                vk_q[freeIdx]   <= bypassK ? cdb_in_data : issue_vk;
                qj_q[freeIdx]   <= bypassJ ? '0 : issue_qj;
                qk_q[freeIdx]   <= bypassK ? '0 : issue_qk;
            end

            case (state_q)
                S_IDLE: begin
                    if (anyReady) begin
                        alu_a            <= vj_q[readyIdx];
                        alu_b            <= op_q[readyIdx] ? ~vk_q[readyIdx] : vk_q[readyIdx];
                        alu_cin          <= op_q[readyIdx];
                        sel_q            <= readyIdx;
                        disp_q[readyIdx] <= 1'b1;
                        cnt_q            <= '0;
                        state_q          <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == CNT_W'(ADD_LAT - 1)) begin
                        cdb_out_data  <= alu_sum;
                        cdb_out_cout  <= alu_cout;
                        cdb_out_tag   <= TAG_W'(RS_BASE) + TAG_W'(sel_q);
                        cdb_out_valid <= 1'b1;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (cdb_out_ready) begin
                        cdb_out_valid <= 1'b0;
                        busy_q[sel_q] <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_rs.sv
// tb_add_rs: directed bench for the adder reservation station, with a
// one-stage registered adder model standing in for the CLA.
module tb_add_rs;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_op;
    logic [31:0] issue_vj;
    logic [31:0] issue_vk;
    logic [3:0]  issue_qj;
    logic [3:0]  issue_qk;
    logic [3:0]  issue_tag;
    logic        cdb_in_valid;
    logic [3:0]  cdb_in_tag;
    logic [31:0] cdb_in_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [31:0] alu_sum;
    logic        alu_cout;
    logic        cdb_out_valid;
    logic        cdb_out_ready;
    logic [3:0]  cdb_out_tag;
    logic [31:0] cdb_out_data;
    logic        cdb_out_cout;

    logic [32:0] sumReg;
    int          checks;
    int          failures;

    add_rs #(
        .ENTRIES(4),
        .TAG_W  (4),
        .RS_BASE(0),
        .ADD_LAT(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_op     (issue_op),
        .issue_vj     (issue_vj),
        .issue_vk     (issue_vk),
        .issue_qj     (issue_qj),
        .issue_qk     (issue_qk),
        .issue_tag    (issue_tag),
        .cdb_in_valid (cdb_in_valid),
        .cdb_in_tag   (cdb_in_tag),
        .cdb_in_data  (cdb_in_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_sum      (alu_sum),
        .alu_cout     (alu_cout),
        .cdb_out_valid(cdb_out_valid),
        .cdb_out_ready(cdb_out_ready),
        .cdb_out_tag  (cdb_out_tag),
        .cdb_out_data (cdb_out_data),
        .cdb_out_cout (cdb_out_cout)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered adder: sum of the operands present one edge earlier.
    always @(posedge clk) begin
        sumReg <= {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
    end

    assign alu_sum  = sumReg[31:0];
    assign alu_cout = sumReg[32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Offer one instruction for a single cycle.
    task automatic applyStimulus(input logic op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [3:0] qj, input logic [3:0] qk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_vj    = vj;
        issue_vk    = vk;
        issue_qj    = qj;
        issue_qk    = qk;
        tick();
        issue_valid = 1'b0;
        issue_qj    = 4'd0;
        issue_qk    = 4'd0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] data);
        cdb_in_valid = 1'b1;
        cdb_in_tag   = tag;
        cdb_in_data  = data;
        tick();
        cdb_in_valid = 1'b0;
        cdb_in_tag   = 4'd0;
    endtask

    task automatic grant();
        cdb_out_ready = 1'b1;
        tick();
        cdb_out_ready = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!cdb_out_valid && n < 12) begin
            tick();
            n++;
        end
        checkOutput({name, "_valid"}, {31'd0, cdb_out_valid}, 32'd1);
    endtask

    task automatic expectResult(input string name, input logic [3:0] tag,
                                input logic [31:0] data, input logic cout);
        waitValid(name);
        checkOutput({name, "_tag"}, {28'd0, cdb_out_tag}, {28'd0, tag});
        checkOutput({name, "_data"}, cdb_out_data, data);
        checkOutput({name, "_cout"}, {31'd0, cdb_out_cout}, {31'd0, cout});
        grant();
        checkOutput({name, "_released"}, {31'd0, cdb_out_valid}, 32'd0);
    endtask

    // Single instruction with both operands present, checking exact latency.
    task automatic runOne(input string name, input logic op, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] expData,
                          input logic expCout);
        applyStimulus(op, vj, vk, 4'd0, 4'd0);
        checkOutput({name, "_tag_next"}, {28'd0, issue_tag}, 32'd1);
        tick();
        checkOutput({name, "_alu_a"}, alu_a, vj);
        checkOutput({name, "_alu_b"}, alu_b, op ? ~vk : vk);
        checkOutput({name, "_alu_cin"}, {31'd0, alu_cin}, {31'd0, op});
        tick();
        checkOutput({name, "_early"}, {31'd0, cdb_out_valid}, 32'd0);
        tick();
        checkOutput({name, "_valid"}, {31'd0, cdb_out_valid}, 32'd1);
        checkOutput({name, "_data"}, cdb_out_data, expData);
        checkOutput({name, "_cout"}, {31'd0, cdb_out_cout}, {31'd0, expCout});
        checkOutput({name, "_tag"}, {28'd0, cdb_out_tag}, 32'd0);
        grant();
        checkOutput({name, "_released"}, {31'd0, cdb_out_valid}, 32'd0);
    endtask

    // Directed sequence covering reset, arithmetic, tag wait, full, priority,
    // dependency through loopback, and reset during execution.
    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        issue_valid   = 1'b0;
        issue_op      = 1'b0;
        issue_vj      = 32'd0;
        issue_vk      = 32'd0;
        issue_qj      = 4'd0;
        issue_qk      = 4'd0;
        cdb_in_valid  = 1'b0;
        cdb_in_tag    = 4'd0;
        cdb_in_data   = 32'd0;
        cdb_out_ready = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        checkOutput("rst_issue_tag", {28'd0, issue_tag}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, cdb_out_valid}, 32'd0);
        checkOutput("rst_out_tag", {28'd0, cdb_out_tag}, 32'd0);
        checkOutput("rst_out_data", cdb_out_data, 32'd0);
        checkOutput("rst_out_cout", {31'd0, cdb_out_cout}, 32'd0);
        checkOutput("rst_alu_a", alu_a, 32'd0);
        checkOutput("rst_alu_b", alu_b, 32'd0);
        checkOutput("rst_alu_cin", {31'd0, alu_cin}, 32'd0);

        runOne("add", 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0);
        runOne("sub_wrap", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        runOne("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);

        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0020, 4'd9, 4'd0);
        tick();
        tick();
        tick();
        checkOutput("wait_no_valid", {31'd0, cdb_out_valid}, 32'd0);
        checkOutput("wait_no_dispatch", alu_a, 32'hFFFF_FFFF);
        checkOutput("wait_issue_tag", {28'd0, issue_tag}, 32'd1);
        cdb_in_valid = 1'b1;
        cdb_in_tag   = 4'd9;
        cdb_in_data  = 32'h0000_0010;
        applyStimulus(1'b0, 32'h0000_BEEF, 32'h0000_0005, 4'd9, 4'd0);
        cdb_in_valid = 1'b0;
        cdb_in_tag   = 4'd0;
        expectResult("tagwait", 4'd0, 32'h0000_0030, 1'b0);
        expectResult("bypass", 4'd1, 32'h0000_0015, 1'b0);

        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0001, 4'd7, 4'd0);
        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0002, 4'd7, 4'd0);
        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0003, 4'd7, 4'd0);
        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0004, 4'd7, 4'd0);
        checkOutput("full_ready", {31'd0, issue_ready}, 32'd0);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0000_0100, 4'd0, 4'd0);
        checkOutput("full_ignored_ready", {31'd0, issue_ready}, 32'd0);
        broadcast(4'd7, 32'h0000_0100);
        waitValid("hold_first");
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold_valid", {31'd0, cdb_out_valid}, 32'd1);
            checkOutput("hold_data", cdb_out_data, 32'h0000_0101);
            checkOutput("hold_tag", {28'd0, cdb_out_tag}, 32'd0);
        end
        grant();
        checkOutput("freed_ready", {31'd0, issue_ready}, 32'd1);
        checkOutput("freed_tag", {28'd0, issue_tag}, 32'd0);
        expectResult("full_e1", 4'd1, 32'h0000_0102, 1'b0);
        expectResult("full_e2", 4'd2, 32'h0000_0103, 1'b0);
        expectResult("full_e3", 4'd3, 32'h0000_0104, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("full_drained_valid", {31'd0, cdb_out_valid}, 32'd0);
        checkOutput("full_drained_tag", {28'd0, issue_tag}, 32'd0);

        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0001, 4'd7, 4'd0);
        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0002, 4'd8, 4'd0);
        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0003, 4'd7, 4'd0);
        broadcast(4'd7, 32'h0000_0010);
        expectResult("prio_e0", 4'd0, 32'h0000_0011, 1'b0);
        expectResult("prio_e2", 4'd2, 32'h0000_0013, 1'b0);
        broadcast(4'd8, 32'h0000_0020);
        expectResult("prio_e1", 4'd1, 32'h0000_0022, 1'b0);

        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0001, 4'd7, 4'd0);
        applyStimulus(1'b0, 32'h0000_0040, 32'h0000_0002, 4'd0, 4'd0);
        applyStimulus(1'b1, 32'hDEAD_0000, 32'h0000_0005, 4'd1, 4'd0);
        waitValid("dep_producer");
        checkOutput("dep_producer_tag", {28'd0, cdb_out_tag}, 32'd1);
        checkOutput("dep_producer_data", cdb_out_data, 32'h0000_0042);
        cdb_in_valid = 1'b1;
        cdb_in_tag   = 4'd1;
        cdb_in_data  = 32'h0000_0042;
        grant();
        cdb_in_valid = 1'b0;
        cdb_in_tag   = 4'd0;
        expectResult("dep_consumer", 4'd2, 32'h0000_003D, 1'b1);
        broadcast(4'd7, 32'h0000_0010);
        expectResult("dep_parked", 4'd0, 32'h0000_0011, 1'b0);

        applyStimulus(1'b0, 32'hDEAD_0000, 32'h0000_0001, 4'd7, 4'd0);
        applyStimulus(1'b0, 32'h0000_0005, 32'h0000_0006, 4'd0, 4'd0);
        tick();
        checkOutput("rstmid_dispatched", alu_a, 32'h0000_0005);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstmid_valid", {31'd0, cdb_out_valid}, 32'd0);
        checkOutput("rstmid_ready", {31'd0, issue_ready}, 32'd1);
        checkOutput("rstmid_tag", {28'd0, issue_tag}, 32'd0);
        checkOutput("rstmid_alu_a", alu_a, 32'd0);
        broadcast(4'd7, 32'h0000_0010);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rstmid_quiet", {31'd0, cdb_out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
